// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, frame constants and the
// parity helper. Kept separate so a future receiver can reuse the same types.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } uart_tx_state_e;

  localparam int unsigned DATA_BITS = 8;

  // Parity bit that makes the total count of ones even (odd = 0) or odd (odd = 1).
  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle for uart_tx.
//   i_data  : byte to send, sampled on acceptance (master -> slave)
//   i_valid : upstream has a byte (master -> slave)
//   o_ready : transmitter can accept a byte this cycle (slave -> master)
//   o_txd   : serial line, idle high (slave -> master)
//   o_busy  : frame in progress (slave -> master)
interface uart_tx_if;

  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_txd;
  logic       o_busy;

  modport master (
    output i_data,
    output i_valid,
    input  o_ready,
    input  o_txd,
    input  o_busy
  );

  modport slave (
    input  i_data,
    input  i_valid,
    output o_ready,
    output o_txd,
    output o_busy
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: 8 data bits LSB first, optional even/odd parity, 1 or 2
// stop bits, fixed baud of CLKS_PER_BIT clocks per bit. No FIFO: a byte is
// taken over the valid/ready handshake only while idle.
//   i_clk  : system clock
//   i_rst  : asynchronous active-high reset (line forced high, frame dropped)
//   tx_if  : slave side of uart_tx_if (i_data/i_valid in; o_ready/o_txd/o_busy out)
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned PARITY_ODD   = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input logic      i_clk,
  input logic      i_rst,
  uart_tx_if.slave tx_if
);

  localparam int unsigned     CntW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitLast   = 3'(DATA_BITS - 1);
  localparam logic            StopLast  = (STOP_BITS == 2);
  localparam logic            ParityEn  = (PARITY_EN != 0);
  localparam logic            ParityOdd = (PARITY_ODD != 0);

  uart_tx_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            stop_cnt_q, stop_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            txd_q, txd_d;
  logic            cnt_done;

  assign cnt_done = (cnt_q == CntLast);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
    end
  end

  // txd_d is the line level for the state being entered, so o_txd is a pure
  // flop output and changes on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    txd_d      = txd_q;

    if (state_q != S_IDLE) begin
      cnt_d = cnt_done ? '0 : cnt_q + CntW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (tx_if.i_valid) begin
          shift_d    = tx_if.i_data;
          parity_d   = parity_bit(tx_if.i_data, ParityOdd);
          cnt_d      = '0;
          bit_idx_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = S_START;
          txd_d      = 1'b0;
        end
      end
      S_START: begin
        if (cnt_done) begin
          state_d = S_DATA;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (cnt_done) begin
          if (bit_idx_q == BitLast) begin
            if (ParityEn) begin
              state_d = S_PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            txd_d     = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (cnt_done) begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
      end
      S_STOP: begin
        txd_d = 1'b1;
        if (cnt_done) begin
          if (stop_cnt_q == StopLast) begin
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  assign tx_if.o_txd   = txd_q;
  assign tx_if.o_ready = (state_q == S_IDLE);
  assign tx_if.o_busy  = (state_q != S_IDLE);

endmodule
